// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the program loader and its counter.
package program_loader_pkg;

  localparam int unsigned IM_DEPTH  = 128;
  localparam int unsigned IM_ADDR_W = 7;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned COUNT_W   = 8;
  localparam int unsigned STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_FULL  = 3'd4,
    ST_DONE  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Loader bus: host byte stream and control in, instruction-memory write port and status out.
interface program_loader_if #(
  parameter int unsigned ADDR_W = program_loader_pkg::IM_ADDR_W
) ();

  logic                                    start;
  logic                                    finish;
  logic [program_loader_pkg::BYTE_W-1:0]   rx_data;
  logic                                    rx_valid;
  logic                                    rx_ready;
  logic [ADDR_W-1:0]                       im_addr;
  logic [program_loader_pkg::WORD_W-1:0]   im_data;
  logic                                    im_wren;
  logic                                    cpu_hold;
  logic [program_loader_pkg::COUNT_W-1:0]  word_count;
  logic                                    overflow;
  logic                                    frame_err;
  logic                                    done;
  logic [program_loader_pkg::STATE_W-1:0]  state;

  modport master (
    output start, finish, rx_data, rx_valid,
    input  rx_ready, im_addr, im_data, im_wren, cpu_hold,
           word_count, overflow, frame_err, done, state
  );

  modport slave (
    input  start, finish, rx_data, rx_valid,
    output rx_ready, im_addr, im_data, im_wren, cpu_hold,
           word_count, overflow, frame_err, done, state
  );

endinterface

// File: rtl/program_loader_load_counter.sv
// Word address/count register: clears on load start, increments per written word, saturates at DEPTH.
module load_counter
  import program_loader_pkg::*;
#(
  parameter int unsigned DEPTH = IM_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               last_o
);

  logic [COUNT_W-1:0] count_q, count_d;
  logic               full_q;
  logic               last_q;

  // Saturating at DEPTH guarantees the write address can never wrap.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !full_q) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == COUNT_W'(DEPTH));
      last_q  <= (count_d == COUNT_W'(DEPTH - 1));
    end
  end

  assign count_o = count_q;
  assign last_o  = last_q;

endmodule

// File: rtl/program_loader.sv
// Streams high/low byte pairs into instruction memory while holding the CPU's PC cleared.
module program_loader #(
  parameter int unsigned IM_DEPTH  = program_loader_pkg::IM_DEPTH,
  parameter int unsigned IM_ADDR_W = program_loader_pkg::IM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  program_loader_if.slave        bus
);

  import program_loader_pkg::*;

  loader_state_t          state_q;
  logic [BYTE_W-1:0]      hi_q;
  logic [IM_ADDR_W-1:0]   im_addr_q;
  logic [WORD_W-1:0]      im_data_q;
  logic                   im_wren_q;
  logic                   cpu_hold_q;
  logic                   done_q;
  logic                   overflow_q;
  logic                   frame_err_q;

  logic                   hs;
  logic                   cnt_clear;
  logic                   cnt_inc;
  logic                   cnt_last;
  logic [COUNT_W-1:0]     cnt;

  // Finish takes precedence over a byte offered in the same cycle.
  assign bus.rx_ready = ((state_q == ST_HI) || (state_q == ST_LO) || (state_q == ST_FULL))
                        && !bus.finish;
  assign hs        = bus.rx_valid && bus.rx_ready;
  assign cnt_clear = (state_q == ST_IDLE) && bus.start;
  assign cnt_inc   = (state_q == ST_WRITE);

  load_counter #(.DEPTH(IM_DEPTH)) u_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .count_o (cnt),
    .last_o  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      im_addr_q   <= '0;
      im_data_q   <= '0;
      im_wren_q   <= 1'b0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      im_wren_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q     <= ST_HI;
            cpu_hold_q  <= 1'b1;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
          end
        end
        ST_HI: begin
          if (bus.finish) begin
            state_q    <= ST_DONE;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b1;
          end else if (hs) begin
            hi_q    <= bus.rx_data;
            state_q <= ST_LO;
          end
        end
        ST_LO: begin
          if (bus.finish) begin
            state_q     <= ST_DONE;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b1;
            frame_err_q <= 1'b1;
          end else if (hs) begin
            // Write-port registers load here so they are valid throughout WRITE.
            im_addr_q <= IM_ADDR_W'(cnt);
            im_data_q <= {hi_q, bus.rx_data};
            im_wren_q <= 1'b1;
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          state_q <= cnt_last ? ST_FULL : ST_HI;
        end
        ST_FULL: begin
          if (bus.finish) begin
            state_q    <= ST_DONE;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b1;
          end else if (hs) begin
            overflow_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          cpu_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.im_addr    = im_addr_q;
  assign bus.im_data    = im_data_q;
  assign bus.im_wren    = im_wren_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.word_count = cnt;
  assign bus.overflow   = overflow_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.done       = done_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: byte framing, write port timing, full/overflow, framing error, reset.
module tb_program_loader;

  import program_loader_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   wren_run;
  int   wren_max_run;

  logic [IM_ADDR_W-1:0] log_addr[$];
  logic [WORD_W-1:0]    log_data[$];
  int                   log_cyc[$];

  program_loader_if lif ();

  program_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (lif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write and the longest run of consecutive write-enable cycles.
  always @(negedge clk) begin
    if (lif.im_wren === 1'b1) begin
      log_addr.push_back(lif.im_addr);
      log_data.push_back(lif.im_data);
      log_cyc.push_back(cyc);
      wren_run = wren_run + 1;
      if (wren_run > wren_max_run) wren_max_run = wren_run;
    end else begin
      wren_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    lif.rx_data  = b;
    lif.rx_valid = 1'b1;
    while (!lif.rx_ready && n < 20) begin
      step();
      n++;
    end
    if (!lif.rx_ready) check("rx_ready_wait", 32'(lif.rx_ready), 32'h1);
    step();
    lif.rx_valid = 1'b0;
  endtask

  task automatic do_start();
    lif.start = 1'b1;
    step();
    lif.start = 1'b0;
  endtask

  task automatic end_load(input string tag);
    lif.finish = 1'b1;
    step();
    check({tag, "_done"}, 32'(lif.done), 32'h1);
    check({tag, "_state_done"}, 32'(lif.state), 32'h5);
    lif.finish = 1'b0;
    step();
    check({tag, "_state_idle"}, 32'(lif.state), 32'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},    32'(lif.state), 32'h0);
    check({tag, "_rx_ready"}, 32'(lif.rx_ready), 32'h0);
    check({tag, "_im_wren"},  32'(lif.im_wren), 32'h0);
    check({tag, "_im_addr"},  32'(lif.im_addr), 32'h0);
    check({tag, "_im_data"},  32'(lif.im_data), 32'h0);
    check({tag, "_cpu_hold"}, 32'(lif.cpu_hold), 32'h0);
    check({tag, "_wcount"},   32'(lif.word_count), 32'h0);
    check({tag, "_overflow"}, 32'(lif.overflow), 32'h0);
    check({tag, "_frame"},    32'(lif.frame_err), 32'h0);
    check({tag, "_done"},     32'(lif.done), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; wren_run = 0; wren_max_run = 0;
    reset = 1'b1;
    lif.start = 1'b0; lif.finish = 1'b0; lif.rx_data = 8'h00; lif.rx_valid = 1'b0;
    step();
    step();
    check_reset_values("rst");
    reset = 1'b0;
    step();

    // Single word 0x010B
    do_start();
    check("w1_state_hi", 32'(lif.state), 32'h1);
    check("w1_hold", 32'(lif.cpu_hold), 32'h1);
    send_byte(8'h01);
    check("w1_state_lo", 32'(lif.state), 32'h2);
    send_byte(8'h0B);
    check("w1_wren", 32'(lif.im_wren), 32'h1);
    check("w1_addr", 32'(lif.im_addr), 32'h0);
    check("w1_data", 32'(lif.im_data), 32'h010B);
    check("w1_wcount_pre", 32'(lif.word_count), 32'h0);
    check("w1_rdy_in_write", 32'(lif.rx_ready), 32'h0);
    step();
    check("w1_wren_off", 32'(lif.im_wren), 32'h0);
    check("w1_wcount", 32'(lif.word_count), 32'h1);
    check("w1_data_hold", 32'(lif.im_data), 32'h010B);
    check("w1_state_back_hi", 32'(lif.state), 32'h1);
    end_load("w1");
    check("w1_hold_idle", 32'(lif.cpu_hold), 32'h0);

    // Back-to-back stream 0x10..0x17
    do_start();
    check("b2b_wcount_clr", 32'(lif.word_count), 32'h0);
    clear_log();
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
    step();
    check("b2b_nwrites", 32'(log_addr.size()), 32'h4);
    if (log_addr.size() == 4) begin
      check("b2b_addr0", 32'(log_addr[0]), 32'h0);
      check("b2b_data0", 32'(log_data[0]), 32'h1011);
      check("b2b_addr1", 32'(log_addr[1]), 32'h1);
      check("b2b_data1", 32'(log_data[1]), 32'h1213);
      check("b2b_addr2", 32'(log_addr[2]), 32'h2);
      check("b2b_data2", 32'(log_data[2]), 32'h1415);
      check("b2b_addr3", 32'(log_addr[3]), 32'h3);
      check("b2b_data3", 32'(log_data[3]), 32'h1617);
      for (int k = 1; k < 4; k++)
        check("b2b_spacing", 32'(log_cyc[k] - log_cyc[k-1]), 32'h3);
    end
    check("b2b_wcount", 32'(lif.word_count), 32'h4);
    end_load("b2b");

    // Finish with half a word pending
    do_start();
    clear_log();
    send_byte(8'h21);
    lif.finish = 1'b1;
    #1;
    check("fe_rdy_finish", 32'(lif.rx_ready), 32'h0);
    step();
    check("fe_state_done", 32'(lif.state), 32'h5);
    check("fe_frame", 32'(lif.frame_err), 32'h1);
    check("fe_done", 32'(lif.done), 32'h1);
    check("fe_hold", 32'(lif.cpu_hold), 32'h0);
    lif.finish = 1'b0;
    step();
    check("fe_state_idle", 32'(lif.state), 32'h0);
    check("fe_done_pulse", 32'(lif.done), 32'h0);
    check("fe_frame_sticky", 32'(lif.frame_err), 32'h1);
    check("fe_nwrites", 32'(log_addr.size()), 32'h0);
    check("fe_wcount", 32'(lif.word_count), 32'h0);

    // Fill memory and overrun by two words
    do_start();
    check("full_frame_clr", 32'(lif.frame_err), 32'h0);
    clear_log();
    for (int i = 0; i < 128; i++) begin
      send_byte(8'(i));
      send_byte(8'(i) ^ 8'hFF);
    end
    step();
    check("full_state", 32'(lif.state), 32'h4);
    check("full_wcount", 32'(lif.word_count), 32'd128);
    check("full_ovf_before", 32'(lif.overflow), 32'h0);
    check("full_hold", 32'(lif.cpu_hold), 32'h1);
    for (int i = 128; i < 130; i++) begin
      send_byte(8'(i));
      send_byte(8'(i) ^ 8'hFF);
    end
    step();
    check("full_ovf", 32'(lif.overflow), 32'h1);
    check("full_wcount_sat", 32'(lif.word_count), 32'd128);
    check("full_nwrites", 32'(log_addr.size()), 32'd128);
    check("full_addr_hold", 32'(lif.im_addr), 32'd127);
    if (log_addr.size() == 128) begin
      int bad;
      bad = 0;
      for (int k = 0; k < 128; k++)
        if (log_addr[k] !== 7'(k) || log_data[k] !== {8'(k), 8'(k) ^ 8'hFF}) bad++;
      check("full_seq_bad", 32'(bad), 32'h0);
      check("full_data127", 32'(log_data[127]), 32'h7F80);
    end
    end_load("full");
    check("full_ovf_sticky", 32'(lif.overflow), 32'h1);

    // Finish and a valid byte together in HI
    do_start();
    clear_log();
    lif.rx_data = 8'h55; lif.rx_valid = 1'b1; lif.finish = 1'b1;
    #1;
    check("fin_rdy", 32'(lif.rx_ready), 32'h0);
    step();
    check("fin_done", 32'(lif.done), 32'h1);
    check("fin_state", 32'(lif.state), 32'h5);
    lif.rx_valid = 1'b0; lif.finish = 1'b0;
    step();
    check("fin_idle", 32'(lif.state), 32'h0);
    check("fin_nwrites", 32'(log_addr.size()), 32'h0);

    // Reset mid-word with a handshake offered on the reset edge
    do_start();
    clear_log();
    send_byte(8'hAA);
    reset = 1'b1;
    lif.rx_data = 8'hBB; lif.rx_valid = 1'b1;
    step();
    check_reset_values("mrst");
    reset = 1'b0; lif.rx_valid = 1'b0;
    step();
    check("mrst_nwrites", 32'(log_addr.size()), 32'h0);
    do_start();
    send_byte(8'h12);
    send_byte(8'h34);
    step();
    check("mrst_nwrites2", 32'(log_addr.size()), 32'h1);
    if (log_addr.size() == 1) begin
      check("mrst_addr", 32'(log_addr[0]), 32'h0);
      check("mrst_data", 32'(log_data[0]), 32'h1234);
    end
    end_load("mrst");

    check("wren_width", 32'(wren_max_run), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter IM_DEPTH, default 128, number of instruction-memory words.
REQ-002 Parameter IM_ADDR_W, default 7, instruction-memory address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a program load; ignored unless in IDLE.
REQ-006 finish  input  1  end of program stream.
REQ-007 rx_data  input  8  program byte, high byte of each word first.
REQ-008 rx_valid  input  1  rx_data valid.
REQ-009 rx_ready  output  1  loader accepts byte this cycle.
REQ-010 im_addr  output  IM_ADDR_W  instruction-memory write address.
REQ-011 im_data  output  16  instruction word to write.
REQ-012 im_wren  output  1  instruction-memory write enable.
REQ-013 cpu_hold  output  1  holds the control unit's PC cleared while loading.
REQ-014 word_count  output  8  words written this load, 0..IM_DEPTH.
REQ-015 overflow  output  1  sticky: byte received after memory full.
REQ-016 frame_err  output  1  sticky: finish arrived with half a word pending.
REQ-017 done  output  1  one-cycle pulse at load completion.
REQ-018 state  output  3  current state encoding, for board display.

Function
REQ-019 States SHALL be IDLE, HI, LO, WRITE, FULL, DONE.
REQ-020 Byte handshake SHALL occur on a rising edge with rx_valid=1 and rx_ready=1.
REQ-021 rx_ready SHALL be 1 only in HI, LO, FULL, and only when finish=0 (combinational).
REQ-022 IDLE: start=1 -> HI; word_count, overflow, frame_err cleared; cpu_hold=1.
REQ-023 HI: handshake captures high byte -> LO; finish=1 -> DONE.
REQ-024 LO: handshake captures low byte -> WRITE; finish=1 -> DONE, frame_err=1, partial byte discarded, no write.
REQ-025 WRITE: im_wren=1 for exactly one cycle, im_addr=word_count[IM_ADDR_W-1:0], im_data={high,low}; word_count increments on that edge.
REQ-026 WRITE exit: -> FULL if incremented word_count equals IM_DEPTH, else -> HI.
REQ-027 Handshake-to-write latency SHALL be one cycle after the low-byte handshake; a byte stream with no gaps sustains one word per 3 cycles.
REQ-028 FULL: accepted bytes discarded, overflow=1, no write; address SHALL NOT wrap; finish=1 -> DONE.
REQ-029 DONE: done=1 and cpu_hold=0 for one cycle, then -> IDLE.
REQ-030 cpu_hold SHALL be 1 in HI, LO, WRITE, FULL; 0 in IDLE and DONE.
REQ-031 im_wren SHALL be 0 in every state except WRITE.
REQ-032 start outside IDLE SHALL be ignored; finish in IDLE SHALL be ignored.
REQ-033 im_addr and im_data SHALL hold their last written values outside WRITE.

Reset
REQ-034 reset=1 SHALL force on the next edge: state IDLE, rx_ready 0, im_wren 0, im_addr 0, im_data 0, cpu_hold 0, word_count 0, overflow 0, frame_err 0, done 0.
REQ-035 reset SHALL take priority over start, finish and any handshake, including mid-word; no write occurs on that edge.

Structure
REQ-036 Shared package SHALL hold loader_state_t enum, IM_DEPTH, IM_ADDR_W and WORD_W=16 constants.
REQ-037 The word address/count logic SHALL be a sub-module load_counter (clear, increment, full flag).
REQ-038 Outputs im_addr, im_data, im_wren SHALL connect directly to the instruction memory write port; cpu_hold SHALL gate the PC clear.

Verification
REQ-039 Reset, start, bytes 0x01,0x0B -> one-cycle im_wren, im_addr 0, im_data 0x010B, word_count 1.
REQ-040 Eight back-to-back bytes 0x10..0x17 -> writes addr 0..3 with 0x1011,0x1213,0x1415,0x1617; three cycles per word.
REQ-041 start, byte 0x21, finish -> no write, frame_err 1, done pulse, cpu_hold 0, then IDLE.
REQ-042 130 words streamed -> writes addr 0..127 only, word_count 128, overflow 1, no wrap to addr 0.
REQ-043 reset after high byte -> all outputs at reset values next edge; next start loads word at addr 0.
REQ-044 finish and rx_valid same cycle in HI -> rx_ready 0, byte not consumed, done pulse next cycle.
